// File: rtl/clk_gen_supervisor.sv
// Supervisor for the MMCM clock generator: pulses its reset, retries on lock
// timeout, and releases downstream domain resets in order once lock is stable.
module clk_gen_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned STABLE_CYCLES    = 1024,
    parameter int unsigned NUM_STAGES       = 4,
    parameter int unsigned STAGE_GAP        = 8,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned CNT_W            = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked_in,
    input  logic                  force_reset,
    output logic                  mmcm_rst,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [3:0]            retry_count,
    output logic [7:0]            lock_loss_count
);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_lock_meta;
    logic                    r_lock_s;
    logic [NUM_STAGES-1:0]   w_stage_next;
    logic [7:0]              w_loss_next;
    logic [3:0]              w_retry_next;
    logic                    w_lock_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= locked_in;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Stages release as a thermometer code growing from bit 0.
    assign w_stage_next = (stage_rst_n << 1) | NUM_STAGES'(1);
    assign w_loss_next  = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
    assign w_retry_next = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
    assign w_lock_drop  = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !r_lock_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_RESET;
            r_cnt           <= '0;
            mmcm_rst        <= 1'b1;
            stage_rst_n     <= '0;
            ready           <= 1'b0;
            fail            <= 1'b0;
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else if (force_reset) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            mmcm_rst    <= 1'b1;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
        end else if (w_lock_drop) begin
            r_state         <= S_RESET;
            r_cnt           <= '0;
            mmcm_rst        <= 1'b1;
            stage_rst_n     <= '0;
            ready           <= 1'b0;
            lock_loss_count <= w_loss_next;
        end else begin
            unique case (r_state)
                S_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        r_state  <= S_WAIT_LOCK;
                        r_cnt    <= '0;
                        mmcm_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt    <= '0;
                        mmcm_rst <= 1'b1;
                        if (32'(retry_count) < MAX_RETRIES) begin
                            r_state     <= S_RESET;
                            retry_count <= w_retry_next;
                        end else begin
                            r_state <= S_FAIL;
                            fail    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    // A dropout here is treated as an unfinished lock, not a loss or retry.
                    if (!r_lock_s) begin
                        r_state  <= S_RESET;
                        r_cnt    <= '0;
                        mmcm_rst <= 1'b1;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (&stage_rst_n) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        ready       <= 1'b1;
                        retry_count <= '0;
                    end else if (r_cnt == GAP_LAST) begin
                        stage_rst_n <= w_stage_next;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                end
                S_FAIL: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state  <= S_RESET;
                    r_cnt    <= '0;
                    mmcm_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_gen_supervisor.md
Name: clk_gen_supervisor

Overview:
- Control-side companion to the MMCM clock generator wrapper.
- Drives the generator's reset input and watches its lock output.
- Retries on lock timeout and releases downstream domain resets in a fixed sequence only after lock has been stable.
- Runs on the free-running input reference clock, the same clock that feeds the MMCM.

Parameters:
- RST_PULSE_CYCLES, 16: cycles mmcm_rst is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- NUM_STAGES, 4: number of sequenced downstream resets (1..16).
- STAGE_GAP, 8: cycles between successive stage releases (min 1).
- MAX_RETRIES, 3: lock timeouts tolerated before entering FAIL.
- CNT_W, 20: width of the shared cycle counter; must hold the largest of the count parameters.

Ports:
- clk  in  1  free-running reference clock.
- rst  in  1  reset; synchronous, active-low.
- locked_in  in  1  MMCM locked; asynchronous to clk.
- force_reset  in  1  single-cycle request to restart the whole sequence.
- mmcm_rst  out  1  reset to the clock generator; active-high.
- stage_rst_n  out  NUM_STAGES  downstream resets, active-low; bit 0 is released first.
- ready  out  1  high in RUN only.
- fail  out  1  high in FAIL only.
- retry_count  out  4  lock timeouts since the last entry to RUN; saturating.
- lock_loss_count  out  8  lock drops seen in RELEASE or RUN; saturating at 255.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=RESET, counter=0;
  - mmcm_rst=1, stage_rst_n=all 0, ready=0, fail=0;
  - retry_count=0, lock_loss_count=0.
- All outputs are registered.
- locked_in passes through a 2-flop synchronizer to produce locked_s, adding 2 cycles of latency. The synchronizer resets to 0.
- RESET:
  - mmcm_rst=1 and stage_rst_n=0.
  - Stay for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with counter=0.
  - mmcm_rst drops on the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - mmcm_rst=0 and the counter increments each cycle.
  - locked_s=1 goes to STABLE with counter=0.
  - If counter reaches LOCK_TIMEOUT-1 without lock:
    - if retry_count < MAX_RETRIES, increment retry_count and go to RESET;
    - otherwise go to FAIL.
- STABLE:
  - locked_s must stay high for STABLE_CYCLES consecutive cycles, then go to RELEASE.
  - Any low cycle goes to RESET. This is not counted as a lock loss and does not count as a retry.
- RELEASE:
  - Every STAGE_GAP cycles, the next stage_rst_n bit goes high, starting with bit 0 STAGE_GAP cycles after entry.
  - Bits stay high once set.
  - When the last bit is set, go to RUN on the following cycle.
- RUN:
  - ready=1 and retry_count is cleared on entry.
  - locked_s=0 goes to RESET.
- Lock drop in RELEASE or RUN:
  - In the next cycle, stage_rst_n=all 0, ready=0 and mmcm_rst=1, all at once.
  - lock_loss_count increments, saturating.
- FAIL:
  - mmcm_rst=1, stage_rst_n=0, fail=1.
  - Leave only on rst or force_reset.
- force_reset=1 in any state:
  - go to RESET next cycle;
  - clear retry_count and counter, clear fail;
  - lock_loss_count is preserved.
  - force_reset takes priority over every other same-cycle event (lock edge, timeout, stage release).
- Reset mid-operation: rst has absolute priority. All outputs return to their reset values on that edge, including while in RELEASE or FAIL.
- Counter arithmetic: unsigned CNT_W bits. It never wraps, because every state exits at or before its terminal count.

Test Plan:
Common parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=2, MAX_RETRIES=2.
- Normal bring-up: rst released at cycle 0; locked_in rises at cycle 10 and holds -> mmcm_rst high cycles 0-3; stage_rst_n goes 001, 011, 111 at 2-cycle spacing; ready=1; retry_count=0.
- Timeout retry: locked_in low for the first 2 attempts, then rises 5 cycles into attempt 3 -> retry_count=2, three mmcm_rst pulses of 4 cycles each, then normal release; retry_count=0 in RUN.
- Exhausted retries: locked_in held low -> after 3 timeouts, fail=1, mmcm_rst=1 and retry_count=2 held; a force_reset pulse then gives fail=0 next cycle and a fresh 4-cycle RESET.
- Glitchy lock: locked_in high 5 cycles, low 1 cycle, high again -> returns to RESET; no stage released; lock_loss_count=0.
- Lock loss in RUN: drop locked_in -> 3 cycles later stage_rst_n=000, ready=0, mmcm_rst=1; lock_loss_count=1; full sequence repeats once lock returns.
- Collisions: force_reset on the same cycle as the last stage release -> RESET; stage_rst_n=000; ready never asserts. Also assert rst=0 mid-RELEASE -> all outputs at reset values on the next edge.
